// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encodings,
// PC-source select codes, opcode values and the opcode-class record.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;  // PC + 4
    localparam logic [1:0] PC_SEL_OFF = 2'd1;  // PC + offset
    localparam logic [1:0] PC_SEL_REG = 2'd2;  // src1 register

    // Opcode values of IR[31:27]; anything not listed executes as a NOP
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_AND  = 5'd1;
    localparam logic [4:0] OP_MOV  = 5'd2;
    localparam logic [4:0] OP_LDW  = 5'd3;
    localparam logic [4:0] OP_STW  = 5'd4;
    localparam logic [4:0] OP_BR   = 5'd5;
    localparam logic [4:0] OP_JMP  = 5'd6;
    localparam logic [4:0] OP_JSR  = 5'd7;
    localparam logic [4:0] OP_JSRR = 5'd8;

    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jsr;
        logic jsrr;
        logic nop;
    } op_class_t;

endpackage

// File: rtl/cpu_sequencer_op_classify.sv
// Combinational opcode decoder producing a one-hot instruction class.
module op_classify
    import cpu_sequencer_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output op_class_t               op_class
);

    // One-hot class lookup; unknown opcodes fall through to nop
    always_comb begin
        op_class = '0;
        case (opcode)
            OPCODE_WIDTH'(OP_ADD),
            OPCODE_WIDTH'(OP_AND),
            OPCODE_WIDTH'(OP_MOV):  op_class.alu    = 1'b1;
            OPCODE_WIDTH'(OP_LDW):  op_class.load   = 1'b1;
            OPCODE_WIDTH'(OP_STW):  op_class.store  = 1'b1;
            OPCODE_WIDTH'(OP_BR):   op_class.branch = 1'b1;
            OPCODE_WIDTH'(OP_JMP):  op_class.jump   = 1'b1;
            OPCODE_WIDTH'(OP_JSR):  op_class.jsr    = 1'b1;
            OPCODE_WIDTH'(OP_JSRR): op_class.jsrr   = 1'b1;
            default:                op_class.nop    = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/[MEM]/WB and drives the datapath strobes.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5,
    parameter int MEM_TIMEOUT  = 15,
    parameter int RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lock,
    input  logic                    halt_req,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    br_taken,
    input  logic                    mem_ready,
    output logic                    ir_load,
    output logic                    pc_write,
    output logic [1:0]              pc_sel,
    output logic                    reg_write,
    output logic                    link_sel,
    output logic                    cc_write,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    busy,
    output logic                    mem_err,
    output logic [RETIRE_WIDTH-1:0] retire_count,
    output logic [2:0]              state
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t                  state_r;
    state_t                  next_state_s;
    logic [WAIT_W-1:0]       wait_cnt_r;
    logic [RETIRE_WIDTH-1:0] retire_count_r;
    op_class_t               op_class_s;
    logic                    retire_s;
    logic                    continue_s;

    op_classify #(
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_op_classify (
        .opcode   (opcode),
        .op_class (op_class_s)
    );

    assign continue_s   = lock & ~halt_req;
    assign retire_count = retire_count_r;
    assign state        = state_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // MEM wait counter; held at zero outside MEM so every entry starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (state_r != ST_MEM) begin
            wait_cnt_r <= '0;
        end else if (!mem_ready && (wait_cnt_r != WAIT_LAST)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count_r <= '0;
        end else if (retire_s) begin
            retire_count_r <= retire_count_r + RETIRE_WIDTH'(1);
        end else begin
            retire_count_r <= retire_count_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (continue_s) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH:  next_state_s = ST_DECODE;
            ST_DECODE: next_state_s = ST_EXEC;
            ST_EXEC: begin
                if (op_class_s.alu) begin
                    next_state_s = ST_WB;
                end else if (op_class_s.load || op_class_s.store) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = continue_s ? ST_FETCH : ST_IDLE;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (op_class_s.load) begin
                        next_state_s = ST_WB;
                    end else begin
                        next_state_s = continue_s ? ST_FETCH : ST_IDLE;
                    end
                end else if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB:   next_state_s = continue_s ? ST_FETCH : ST_IDLE;
            ST_ERR:  next_state_s = ST_ERR;
            default: next_state_s = ST_ERR;
        endcase
    end

    // Output decode; EXEC and MEM retire strobes also depend on br_taken/mem_ready
    always_comb begin
        ir_load   = 1'b0;
        retire_s  = 1'b0;
        pc_sel    = PC_SEL_SEQ;
        reg_write = 1'b0;
        link_sel  = 1'b0;
        cc_write  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        mem_err   = 1'b0;
        case (state_r)
            ST_IDLE:   busy    = 1'b0;
            ST_FETCH:  ir_load = 1'b1;
            ST_DECODE: busy    = 1'b1;
            ST_EXEC: begin
                retire_s = op_class_s.branch | op_class_s.jump | op_class_s.jsr |
                           op_class_s.jsrr | op_class_s.nop;
                if (op_class_s.branch) begin
                    pc_sel = br_taken ? PC_SEL_OFF : PC_SEL_SEQ;
                end else if (op_class_s.jump || op_class_s.jsrr) begin
                    pc_sel = PC_SEL_REG;
                end else if (op_class_s.jsr) begin
                    pc_sel = PC_SEL_OFF;
                end else begin
                    pc_sel = PC_SEL_SEQ;
                end
                reg_write = op_class_s.jsr | op_class_s.jsrr;
                link_sel  = op_class_s.jsr | op_class_s.jsrr;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = op_class_s.store;
                retire_s = mem_ready & ~op_class_s.load;
            end
            ST_WB: begin
                retire_s  = 1'b1;
                reg_write = 1'b1;
                cc_write  = 1'b1;
            end
            ST_ERR:  mem_err = 1'b1;
            default: mem_err = 1'b1;
        endcase
        pc_write = retire_s;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed, table-driven bench for cpu_sequencer with hand-written
// sequences for back-to-back, lock drop, timeout and mid-MEM reset.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lock, halt_req, br_taken, mem_ready;
    logic [4:0]  opcode;
    logic        ir_load, pc_write, reg_write, link_sel, cc_write;
    logic        mem_req, mem_we, busy, mem_err;
    logic [1:0]  pc_sel;
    logic [15:0] retire_count;
    logic [2:0]  state;

    int errors = 0;
    int checks = 0;

    cpu_sequencer #(
        .OPCODE_WIDTH (5),
        .MEM_TIMEOUT  (15),
        .RETIRE_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lock         (lock),
        .halt_req     (halt_req),
        .opcode       (opcode),
        .br_taken     (br_taken),
        .mem_ready    (mem_ready),
        .ir_load      (ir_load),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .reg_write    (reg_write),
        .link_sel     (link_sel),
        .cc_write     (cc_write),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .busy         (busy),
        .mem_err      (mem_err),
        .retire_count (retire_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [4:0] op;
        logic       br;
        int         dly;   // MEM cycles before mem_ready
        int         lat;   // FETCH..retire cycles, inclusive
        int         nreq;  // cycles with mem_req high
        logic [1:0] sel;
        logic       rw;
        logic       link;
        logic       cc;
        logic       we;
    } vec_t;

    localparam int NV = 13;
    vec_t vec [NV];

    int          cyc, memc, nreq;
    logic        done;
    logic [15:0] rc0;
    logic [4:0]  op_nop;

    initial begin
        op_nop = 5'd31;
        vec[0]  = '{OP_ADD,  1'b0, 0, 4, 0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[1]  = '{OP_AND,  1'b0, 0, 4, 0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{OP_MOV,  1'b1, 0, 4, 0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{OP_BR,   1'b1, 0, 3, 0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[4]  = '{OP_BR,   1'b0, 0, 3, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[5]  = '{OP_JMP,  1'b0, 0, 3, 0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{OP_JSR,  1'b0, 0, 3, 0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[7]  = '{OP_JSRR, 1'b1, 0, 3, 0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[8]  = '{op_nop,  1'b1, 0, 3, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[9]  = '{OP_LDW,  1'b0, 3, 8, 4, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[10] = '{OP_LDW,  1'b0, 0, 5, 1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vec[11] = '{OP_STW,  1'b0, 2, 6, 3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[12] = '{OP_STW,  1'b0, 0, 4, 1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst_n = 1'b0; lock = 1'b0; halt_req = 1'b0; br_taken = 1'b0;
        mem_ready = 1'b0; opcode = OP_ADD;
        #12;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_retire", retire_count, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_strobes", {ir_load, pc_write, reg_write, link_sel, cc_write, mem_req, mem_we}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("idle_no_lock", state, 0);

        // Table: one instruction each, halt at retire parks in IDLE
        for (int i = 0; i < NV; i++) begin
            opcode = vec[i].op; br_taken = vec[i].br;
            lock = 1'b1; halt_req = 1'b0; mem_ready = 1'b0;
            rc0 = retire_count;
            tick();
            halt_req = 1'b1;
            chk("fetch_state", state, 1);
            chk("fetch_ir_load", ir_load, 1);
            cyc = 1; memc = 0; nreq = 0; done = 1'b0;
            while (!done && cyc < 40) begin
                mem_ready = (state == 3'd4) && (memc == vec[i].dly);
                #1;
                if (mem_req) nreq++;
                if (state == 3'd4) memc++;
                if (pc_write) begin
                    done = 1'b1;
                end else begin
                    tick();
                    cyc++;
                end
            end
            chk("retire_seen", done, 1);
            chk("latency", cyc, vec[i].lat);
            chk("mem_req_cycles", nreq, vec[i].nreq);
            chk("ret_pc_sel", pc_sel, vec[i].sel);
            chk("ret_reg_write", reg_write, vec[i].rw);
            chk("ret_link_sel", link_sel, vec[i].link);
            chk("ret_cc_write", cc_write, vec[i].cc);
            chk("ret_mem_we", mem_we, vec[i].we);
            tick();
            mem_ready = 1'b0;
            chk("park_idle", state, 0);
            chk("retire_inc", retire_count, rc0 + 16'd1);
        end

        // Back-to-back: halt pulse away from retire is ignored
        rc0 = retire_count;
        opcode = OP_ADD; br_taken = 1'b0; lock = 1'b1; halt_req = 1'b0;
        tick();
        chk("b2b_fetch1", state, 1);
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("b2b_exec", state, 3);
        tick();
        chk("b2b_wb_retire", {state, pc_write}, {3'd5, 1'b1});
        tick();
        chk("b2b_fetch2", state, 1);
        opcode = OP_BR;
        tick();
        tick();
        halt_req = 1'b1;
        #1;
        chk("b2b_br_retire", {pc_write, pc_sel}, {1'b1, 2'd0});
        tick();
        chk("b2b_idle", state, 0);
        chk("b2b_count", retire_count, rc0 + 16'd2);

        // JSRR with lock dropped in DECODE still completes, then parks
        opcode = OP_JSRR; lock = 1'b1; halt_req = 1'b0;
        tick();
        tick();
        chk("jsrr_decode", state, 2);
        lock = 1'b0;
        tick();
        chk("jsrr_retire", {pc_write, pc_sel, reg_write, link_sel}, {1'b1, 2'd2, 1'b1, 1'b1});
        tick();
        chk("jsrr_idle", state, 0);
        tick();
        chk("jsrr_stay_idle", state, 0);

        // Reset asserted during MEM
        opcode = OP_LDW; lock = 1'b1; mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 10 && state != 3'd4; k++) tick();
        chk("rstmem_reach", state, 4);
        chk("rstmem_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmem_state", state, 0);
        chk("rstmem_req_low", mem_req, 0);
        chk("rstmem_count", retire_count, 0);
        lock = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // STW never ready: timeout after 15 MEM cycles
        opcode = OP_STW; lock = 1'b1; halt_req = 1'b0; mem_ready = 1'b0;
        tick();
        memc = 0;
        for (int k = 0; k < 40 && state != 3'd6; k++) begin
            if (state == 3'd4) memc++;
            tick();
        end
        chk("to_state", state, 6);
        chk("to_mem_cycles", memc, 15);
        chk("to_mem_err", mem_err, 1);
        chk("to_busy", busy, 1);
        chk("to_strobes", {ir_load, pc_write, reg_write, link_sel, cc_write, mem_req, mem_we}, 0);
        mem_ready = 1'b1;
        tick();
        chk("to_sticky", {state, mem_err}, {3'd6, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("to_reset_clear", {state, mem_err, busy}, {3'd0, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the single-issue integer datapath. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB. It drives the datapath's load enables, PC-source select and data-memory handshake from the IR opcode and the branch-condition result. It replaces the free-running fetch-every-edge behaviour with explicit, stallable stages.

## Interface
- `OPCODE_WIDTH`, 5, width of IR[31:27] opcode field
- `MEM_TIMEOUT`, 15, max MEM cycles without `mem_ready` before error (≥1)
- `RETIRE_WIDTH`, 16, width of retired-instruction counter

- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `lock`  in  1  run enable; sampled only in IDLE and at retire
- `halt_req`  in  1  stop after current instruction retires
- `opcode`  in  OPCODE_WIDTH  IR[31:27], valid from DECODE onward
- `br_taken`  in  1  branch condition (nzp vs CC) from datapath, valid in EXEC
- `mem_ready`  in  1  data memory accepts/completes current access
- `ir_load`  out  1  load IR from instruction memory
- `pc_write`  out  1  update PC
- `pc_sel`  out  2  0 = PC+4, 1 = PC+offset, 2 = src1 register
- `reg_write`  out  1  write destination register (R7 for link ops)
- `link_sel`  out  1  destination forced to R7, data = PC
- `cc_write`  out  1  update CC from result
- `mem_req`  out  1  data-memory access request
- `mem_we`  out  1  access is a store (valid with `mem_req`)
- `busy`  out  1  state ≠ IDLE
- `mem_err`  out  1  sticky memory timeout flag
- `retire_count`  out  RETIRE_WIDTH  instructions retired
- `state`  out  3  current state, for debug

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- IDLE: if `lock` and not `halt_req`, go to FETCH.
- FETCH: `ir_load`=1 for one cycle, then DECODE.
- DECODE: register read cycle, then EXEC.
- EXEC, by opcode class:
  - ADD/AND/MOV: go to WB.
  - LDW/STW: go to MEM.
  - BR: retire now with `pc_sel` = 1 if `br_taken`, else 0.
  - JMP: retire with `pc_sel`=2.
  - JSR: retire with `pc_sel`=1, `reg_write`=`link_sel`=1.
  - JSRR: retire with `pc_sel`=2, `reg_write`=`link_sel`=1.
  - Other opcodes: retire as NOP with `pc_sel`=0.
- MEM: hold `mem_req`=1 (`mem_we`=1 for STW) until `mem_ready`.
  - LDW: on `mem_ready`, go to WB.
  - STW: on `mem_ready`, retire in that cycle with `pc_sel`=0.
- WB: `reg_write`=`cc_write`=1, retire with `pc_sel`=0.
- Retire cycle: `pc_write`=1 and `retire_count`+1 (wraps modulo 2^RETIRE_WIDTH). Next state is FETCH if `lock` and not `halt_req`, else IDLE.
- Dropping `lock` mid-instruction never aborts; the instruction completes and the sequencer then parks in IDLE.
- Timeout: `wait_cnt` clears on MEM entry and increments each MEM cycle without `mem_ready`. If `mem_ready`=0 while `wait_cnt`=MEM_TIMEOUT−1, go to ERR.
- ERR: all strobes 0, `mem_err`=1, `busy`=1. Exit only via reset.

## Timing
- Reset (async): state=IDLE. All strobes, `busy`, `mem_err` and `retire_count` = 0. `pc_sel`=0.
- All outputs are registered-state decodes (Moore), except `pc_write`/`pc_sel`/`retire` in EXEC (depend on `br_taken`) and MEM (depend on `mem_ready`).
- Latency from FETCH to retire, counted in cycles:
  - BR/JMP/JSR/JSRR/NOP: 3
  - ALU: 4
  - STW: 4 + w
  - LDW: 5 + w
  - w = MEM cycles without ready.
- Back-to-back instructions: FETCH of the next instruction is the cycle after retire; there are no bubbles beyond this.
- `mem_ready` is honoured in the first MEM cycle. `mem_req` deasserts the cycle after acceptance.
- A `halt_req` pulse is observed only at retire; it is not latched.

## Structure
- Shared package/header: state encodings, `pc_sel` codes, and the opcode defines (`OP_ADD` … `OP_JSR`, alongside the existing `global_def.h` opcodes).
- Sub-module `op_classify`: combinational opcode → one-hot class {alu, load, store, branch, jump, jsr, jsrr, nop}.
- Top level holds the FSM, `wait_cnt` ($clog2(MEM_TIMEOUT) bits) and `retire_count`.

## Test plan
- Reset, then `lock`=1, opcode=OP_ADD -> states 1,2,3,5. `reg_write`, `cc_write` and `pc_write` (sel 0) pulse in cycle 4; `retire_count`=1.
- OP_BR with `br_taken`=1, then with `br_taken`=0 -> retire in EXEC with `pc_sel`=1, then 0. No WB.
- OP_LDW with `mem_ready` delayed 3 cycles -> `mem_req` high for 4 cycles. WB follows; total 8 cycles.
- OP_STW with `mem_ready` never asserted, MEM_TIMEOUT=15 -> after 15 MEM cycles, state=6, `mem_err`=1, all strobes 0.
- OP_JSRR followed by `lock` dropped during DECODE -> retires with `pc_sel`=2, `link_sel`=1, then IDLE.
- `rst_n` low during MEM -> immediate IDLE, `mem_req`=0. Counters are 0 before the next clock.
